// File: rtl/ttl_updn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ttl_updn_pkg
// Description : Shared constants and digit arithmetic for the cascaded
//               up/down counter. The macro DECADE_EN selects BCD digits
//               (MAX = 9); without it, digits are binary modulo 16.
// Revision    : 1.0  initial release
// ============================================================================
package ttl_updn_pkg;

  localparam int         DW      = 4;
  localparam logic [3:0] BIN_MAX = 4'd15;
  localparam logic [3:0] BCD_MAX = 4'd9;

`ifdef DECADE_EN
  localparam bit DECADE_MODE = 1'b1;
`else
  localparam bit DECADE_MODE = 1'b0;
`endif

  // Next value of one digit. In decade mode, illegal codes 10..15 recover
  // to 0 when counting up and to 9 when counting down. The direction select
  // is a conditional operator so an unknown direction yields an unknown
  // digit instead of silently picking one way.
  function automatic logic [DW-1:0] next_digit(input logic [DW-1:0] val,
                                               input logic          up,
                                               input logic          decade);
    logic [DW-1:0] inc;
    logic [DW-1:0] dec;
    if (decade) begin
      inc = (val >= BCD_MAX) ? 4'd0 : val + 4'd1;
      dec = ((val == 4'd0) || (val > BCD_MAX)) ? BCD_MAX : val - 4'd1;
    end else begin
      inc = val + 4'd1;
      dec = val - 4'd1;
    end
    return up ? inc : dec;
  endfunction

  // Terminal count of one digit for the current direction. Illegal BCD
  // codes never match, because only the exact MAX or zero is compared.
  function automatic logic digit_tc(input logic [DW-1:0] val,
                                    input logic          up,
                                    input logic          decade);
    logic [DW-1:0] max_val;
    max_val = decade ? BCD_MAX : BIN_MAX;
    return up ? (val == max_val) : (val == 4'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttl_updn_stage.sv
`default_nettype none
// ============================================================================
// Module      : ttl_updn_stage
// Description : One 4-bit presettable up/down digit with terminal-count
//               flag. BCD or binary behaviour follows DECADE_EN via the
//               package default of the DECADE parameter.
// Revision    : 1.0  initial release
// ============================================================================
module ttl_updn_stage
  import ttl_updn_pkg::*;
#(
  parameter bit DECADE = DECADE_MODE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          cnt_en,
  input  logic          updn,
  output logic [DW-1:0] q,
  output logic          tc
);

  // Digit register: reset beats load, load beats counting, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= cnt_en ? next_digit(q, updn, DECADE) : q;
    end
  end

  assign tc = digit_tc(q, updn, DECADE);

endmodule
`default_nettype wire

// File: rtl/ttl_updn_cascade.sv
`default_nettype none
// ============================================================================
// Module      : ttl_updn_cascade
// Description : Multi-digit synchronous up/down counter built from cascaded
//               4-bit stages. Each digit is enabled by the terminal counts
//               of all digits below it, so carry/borrow resolves across the
//               whole chain in a single edge. Define DECADE_EN for BCD digits.
// Revision    : 1.0  initial release
// ============================================================================
module ttl_updn_cascade
  import ttl_updn_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_n,
  input  logic                 updn,
  input  logic                 load_n,
  input  logic [STAGES*DW-1:0] d,
  output logic [STAGES*DW-1:0] q,
  output logic                 maxmin,
  output logic                 rco_n,
  output logic [STAGES-1:0]    stage_tc
);

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic cnt_en;

    // Each digit's enable is an AND over every lower terminal count, taken
    // directly from stage_tc rather than chained, so no signal feeds itself.
    if (i == 0) begin : g_lsd
      assign cnt_en = ~en_n;
    end else begin : g_upper
      assign cnt_en = ~en_n & (&stage_tc[i-1:0]);
    end

    ttl_updn_stage u_stage (
      .clk    (clk),
      .rst    (rst),
      .load   (~load_n),
      .d      (d[i*DW +: DW]),
      .cnt_en (cnt_en),
      .updn   (updn),
      .q      (q[i*DW +: DW]),
      .tc     (stage_tc[i])
    );
  end

  assign maxmin = &stage_tc;

  // Ripple clock out is low only in the clock-low phase before a wrapping edge.
  assign rco_n = ~(maxmin & ~en_n & ~clk);

endmodule
`default_nettype wire

// File: tb/tb_ttl_updn_cascade.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttl_updn_cascade
// Description : Self-checking bench for ttl_updn_cascade (STAGES = 4).
//               The reference model keeps the counter as a plain integer
//               modulo BASE**4 (BASE = 10 with DECADE_EN, else 16).
// Revision    : 1.0  initial release
// ============================================================================
module tb_ttl_updn_cascade;

  localparam int S = 4;
`ifdef DECADE_EN
  localparam int BASE = 10;
`else
  localparam int BASE = 16;
`endif
  localparam int MOD = BASE * BASE * BASE * BASE;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          en_n   = 1'b1;
  logic          updn   = 1'b1;
  logic          load_n = 1'b1;
  logic [S*4-1:0] d     = '0;
  logic [S*4-1:0] q;
  logic          maxmin;
  logic          rco_n;
  logic [S-1:0]  stage_tc;

  int tests = 0;
  int fails = 0;
  int m     = 0;

  ttl_updn_cascade #(.STAGES(S), .DW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_n     (en_n),
    .updn     (updn),
    .load_n   (load_n),
    .d        (d),
    .q        (q),
    .maxmin   (maxmin),
    .rco_n    (rco_n),
    .stage_tc (stage_tc)
  );

  always #5 clk = ~clk;

  function automatic int q2v(input logic [S*4-1:0] x);
    int v = 0;
    for (int i = S - 1; i >= 0; i--) v = v * BASE + int'(x[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [S*4-1:0] v2q(input int v);
    logic [S*4-1:0] r;
    int t = v;
    for (int i = 0; i < S; i++) begin
      r[i*4 +: 4] = 4'(t % BASE);
      t = t / BASE;
    end
    return r;
  endfunction

  function automatic logic mm_exp(input int v, input logic up);
    return up ? (v == MOD - 1) : (v == 0);
  endfunction

  function automatic logic [S-1:0] tc_exp(input int v, input logic up);
    logic [S-1:0] r;
    int t = v;
    for (int i = 0; i < S; i++) begin
      r[i] = up ? ((t % BASE) == BASE - 1) : ((t % BASE) == 0);
      t = t / BASE;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the rules to the inputs seen there.
  task automatic tick();
    logic r, l, e, u;
    logic [S*4-1:0] dv;
    r = rst; l = load_n; e = en_n; u = updn; dv = d;
    @(posedge clk);
    #1;
    if (r)       m = 0;
    else if (!l) m = q2v(dv);
    else if (!e) m = u ? (m + 1) % MOD : (m + MOD - 1) % MOD;
  endtask

  // Full output check while clk is high (rco_n must be inactive then).
  task automatic chk_state(input string tag);
    chk({tag, ".q"},        32'(q),        32'(v2q(m)));
    chk({tag, ".maxmin"},   32'(maxmin),   32'(mm_exp(m, updn)));
    chk({tag, ".stage_tc"}, 32'(stage_tc), 32'(tc_exp(m, updn)));
    chk({tag, ".rco_n"},    32'(rco_n),    32'(1'b1));
  endtask

  // rco_n check during the clock-low phase.
  task automatic chk_rco(input string tag);
    @(negedge clk);
    #1;
    chk(tag, 32'(rco_n), 32'(!(mm_exp(m, updn) && !en_n)));
  endtask

  initial begin
    // Reset from an arbitrary loaded value
    load_n = 1'b0; d = 16'($urandom); tick();
    load_n = 1'b1; rst = 1'b1; updn = 1'b0; tick();
    chk("reset.q", 32'(q), 32'h0);
    chk("reset.maxmin", 32'(maxmin), 32'h1);
    chk("reset.stage_tc", 32'(stage_tc), 32'hF);
    chk_state("reset");
    rst = 1'b0;

    // Reset beats load in the same edge; load then beats counting
    rst = 1'b1; load_n = 1'b0; d = 16'h1234; en_n = 1'b0; updn = 1'b1; tick();
    chk("prio.rst", 32'(q), 32'h0);
    rst = 1'b0; tick();
    chk("prio.load", 32'(q), 32'h1234);
    chk_state("prio");
    load_n = 1'b1;

`ifdef DECADE_EN
    // BCD carry across two digits
    load_n = 1'b0; d = 16'h0099; updn = 1'b1; en_n = 1'b0; tick();
    load_n = 1'b1; tick();
    chk("bcd_up.q", 32'(q), 32'h0100);
    chk_state("bcd_up");

    // Illegal code: no terminal count, recovers to 9 counting down
    load_n = 1'b0; d = 16'h000C; updn = 1'b0; en_n = 1'b1; tick();
    load_n = 1'b1;
    chk("bcd_ill.stage_tc", 32'(stage_tc), 32'hE);
    chk("bcd_ill.maxmin", 32'(maxmin), 32'h0);
    en_n = 1'b0; tick();
    chk("bcd_ill.q", 32'(q), 32'h0009);
    m = 9;

    // Whole-chain borrow wrap
    load_n = 1'b0; d = 16'h0000; updn = 1'b0; en_n = 1'b0; tick();
    load_n = 1'b1;
    chk("bcd_wrap.maxmin", 32'(maxmin), 32'h1);
    chk_rco("bcd_wrap.rco_n");
    tick();
    chk("bcd_wrap.q", 32'(q), 32'h9999);
    chk_state("bcd_wrap");
`else
    // Load then count up through a digit carry
    load_n = 1'b0; d = 16'h00FE; updn = 1'b1; en_n = 1'b0; tick();
    load_n = 1'b1;
    chk_state("up.load");
    tick(); chk("up.q1", 32'(q), 32'h00FF); chk_state("up1");
    chk("up.tc0_hi", 32'(stage_tc[0]), 32'h1);
    tick(); chk("up.q2", 32'(q), 32'h0100); chk_state("up2");
    tick(); chk("up.q3", 32'(q), 32'h0101); chk_state("up3");

    // Whole-chain wrap with rco pulse
    load_n = 1'b0; d = 16'hFFFF; tick();
    load_n = 1'b1;
    chk("wrap.maxmin", 32'(maxmin), 32'h1);
    @(negedge clk); #1;
    chk("wrap.rco_low", 32'(rco_n), 32'h0);
    tick();
    chk("wrap.q", 32'(q), 32'h0000);
    chk("wrap.maxmin_after", 32'(maxmin), 32'h0);
    chk("wrap.rco_after", 32'(rco_n), 32'h1);

    // Inhibit, then count down
    load_n = 1'b0; d = 16'h0100; en_n = 1'b1; tick();
    load_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk_rco("inh.rco_n");
      tick();
      chk("inh.q", 32'(q), 32'h0100);
    end
    updn = 1'b0; en_n = 1'b0;
    tick(); chk("dn.q1", 32'(q), 32'h00FF); chk_state("dn1");
    tick(); chk("dn.q2", 32'(q), 32'h00FE); chk_state("dn2");

    // Direction flip at zero: maxmin follows immediately
    load_n = 1'b0; d = 16'h0000; en_n = 1'b1; tick();
    load_n = 1'b1;
    updn = 1'b1; #1;
    chk("flip.up", 32'(maxmin), 32'h0);
    updn = 1'b0; #1;
    chk("flip.dn", 32'(maxmin), 32'h1);
`endif

    // Randomized traffic against the integer model
    for (int it = 0; it < 300; it++) begin
      int v;
      rst    = ($urandom % 25) == 0;
      load_n = !(($urandom % 8) == 0);
      en_n   = ($urandom % 4) == 0;
      if (($urandom % 8) == 0) updn = ~updn;
      if ($urandom % 2) v = int'($urandom % MOD);
      else if ($urandom % 2) v = MOD - 1 - int'($urandom % 3);
      else v = int'($urandom % 3);
      d = v2q(v);
      chk_rco("rand.rco_n");
      tick();
      chk_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
